srl_fifo_param: RTL
===================

# srl_fifo_param

Parametrised successor to the team's 8×16 SRL FIFO: a shift-register-based synchronous FIFO with configurable width and depth. It adds correct simultaneous read/write handling, an occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It sits between byte/word producers (UART, command parsers) and consumers inside the FPGA datapath. Storage is kept reset-free so it maps to SRL primitives.

## Interface
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 16: entries; power of two, 2..64.
- `AFULL_LVL`, DEPTH-2: `almost_full` asserts when count ≥ AFULL_LVL.
- `AEMPTY_LVL`, 2: `almost_empty` asserts when count ≤ AEMPTY_LVL.
- `CW`, derived as $clog2(DEPTH+1): count width; not to be overridden.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
- `wr`  in  1  write strobe; pushes `din` at the clock edge.
- `rd`  in  1  read strobe; pops the entry shown on `dout`.
- `din`  in  WIDTH  write data.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `dout`  out  WIDTH  oldest entry; combinational from storage, first-word-fall-through.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `almost_empty`  out  1  count ≤ AEMPTY_LVL.
- `almost_full`  out  1  count ≥ AFULL_LVL.
- `count`  out  CW  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was dropped.
- `underflow`  out  1  sticky: a read hit an empty FIFO.

## Operation
- Storage: DEPTH×WIDTH shift register with no reset. On an accepted write, entry[i] ← entry[i−1] and entry[0] ← din.
- Read pointer `addr` (log2 DEPTH bits) equals count−1 whenever count > 0. `dout` = entry[addr]. When empty, `dout` is don't-care and the bench must not check it.
- Accepted write: `wr & (~full | rd)`.
- Accepted read: `rd & ~empty`.
- Per-cycle update, based on accepted operations:
  - write only: count+1, addr+1, except that addr stays 0 when going from 0 to 1.
  - read only: count−1, addr−1, except that addr stays 0 when going from 1 to 0.
  - both: count and addr unchanged. The shift occurs and the popped entry is the one shown on `dout` before the edge.
  - neither: hold.
- Full with wr&rd: both are accepted and the count stays DEPTH. This is not an overflow.
- Empty with wr&rd: only the write is accepted, count becomes 1, and `underflow` sets.
- `wr & full & ~rd`: the write is dropped, storage does not shift, and `overflow` sets.
- `rd & empty`: no change to state, and `underflow` sets.
- Error flags stay set until `clr_err`. If `clr_err` and a new error occur in the same cycle, the flag remains set; the set wins.
- Status outputs are decoded combinationally from the registered `count`. There is no additional register stage.
- Reset values: count=0, addr=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Storage contents are undefined.

## Timing
- Write-to-read latency is 1 cycle. Data written at edge N is visible on `dout`, with `empty`=0, after edge N.
- Read is zero-latency. `dout` is valid in the same cycle `rd` is asserted, and advances after the edge.
- All flags and `count` change only on `clk` edges or on reset assertion.
- Reset asserted mid-operation clears count, addr and flags immediately (asynchronously). Deassertion is expected to be synchronised externally.
- The first accepted operation occurs at the first edge with `rst` high.

## Structure
- The `fifo_pkg` package holds a `clog2`-style constant function and the error-flag bit indices. No other shared typedefs are needed.
- One sub-module, `srl_shreg`: parametrised WIDTH×DEPTH, with inputs `clk`, `en`, `din` and `addr`, and output `q`. It has no reset, which guarantees SRL inference.
- The control logic (count, addr, flags) lives in `srl_fifo_param`.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, AFULL_LVL=14, AEMPTY_LVL=2.
- Reset, then 3 writes of 0xA1, 0xA2, 0xA3, then 3 reads → `dout` shows 0xA1, 0xA2, 0xA3 in that order; count goes 3→0; `empty` reasserts after the third read.
- 16 writes of 0x00..0x0F → `full`=1, count=16, `almost_full` set from count 14. A 17th write of 0xFF → `overflow`=1, count stays 16, and reading all 16 entries returns 0x00..0x0F.
- Full FIFO, one cycle with wr&rd and din=0x55 → count stays 16, `dout` moves from 0x00 to 0x01, `overflow`=0, and 0x55 is read last.
- Empty FIFO, rd alone → `underflow`=1, count=0. Then wr&rd with 0x77 → count=1 and `dout`=0x77. Then `clr_err` → `underflow`=0.
- Count at 5, continuous wr&rd for 20 cycles with an incrementing din → count stays 5, and output order matches the input order delayed by 5 entries.
- Reset asserted at count=9 mid-burst → `empty`=1, count=0 and flags=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the parametrised SRL FIFO.
//   clog2()          - constant ceiling-log2, used for count and address widths
//   ERR_OVF/ERR_UNF  - bit positions of the sticky error flags in the error vector
package fifo_pkg;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;
  localparam int ERR_W   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/srl_shreg.sv
// srl_shreg: WIDTH x DEPTH shift register with a random-access read tap.
// Kept free of any reset so synthesis can map it onto SRL primitives.
//   clk  - rising-edge clock
//   en   - shift enable: entry[i] <= entry[i-1], entry[0] <= din
//   din  - data shifted into entry 0
//   addr - read tap select
//   q    - entry[addr], combinational
module srl_shreg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign q = mem[addr];

endmodule

// File: rtl/srl_fifo_param.sv
// srl_fifo_param: shift-register FIFO, first-word-fall-through.
// New data always enters entry 0; the read tap addr points at the oldest
// entry (count-1), so a read only moves the tap and never moves data.
//   clk          - rising-edge clock
//   rst          - asynchronous active-low reset (control state only)
//   wr, din      - write strobe and data
//   rd           - read strobe; pops the entry on dout
//   clr_err      - synchronous clear of the sticky error flags
//   dout         - oldest entry (don't-care when empty)
//   empty, full, almost_empty, almost_full, count - occupancy status
//   overflow     - sticky: a write was dropped
//   underflow    - sticky: a read hit an empty FIFO
module srl_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int CW         = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = clog2(DEPTH);

  logic [CW-1:0]    count_q;
  logic [AW-1:0]    addr_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_set;
  logic             wr_acc;
  logic             rd_acc;

  // A write into a full FIFO is still accepted when a read frees a slot
  // in the same cycle.
  assign wr_acc = wr & (~full | rd);
  assign rd_acc = rd & ~empty;

  always_comb begin
    err_set          = '0;
    err_set[ERR_OVF] = wr & full & ~rd;
    err_set[ERR_UNF] = rd & empty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      addr_q  <= '0;
      err_q   <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10: begin
          count_q <= count_q + CW'(1);
          // First entry lands at index 0, which is already where the tap sits.
          if (count_q != '0) addr_q <= addr_q + AW'(1);
        end
        2'b01: begin
          count_q <= count_q - CW'(1);
          if (count_q != CW'(1)) addr_q <= addr_q - AW'(1);
        end
        default: ;
      endcase
      // A new error in the same cycle as clr_err keeps the flag set.
      err_q <= (err_q & ~{ERR_W{clr_err}}) | err_set;
    end
  end

  srl_shreg #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_shreg (
    .clk  (clk),
    .en   (wr_acc),
    .din  (din),
    .addr (addr_q),
    .q    (dout)
  );

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_empty = (count_q <= CW'(AEMPTY_LVL));
  assign almost_full  = (count_q >= CW'(AFULL_LVL));
  assign overflow     = err_q[ERR_OVF];
  assign underflow    = err_q[ERR_UNF];

endmodule
